// File: rtl/ervp_multi_switch_counter_pkg.sv
// Shared definitions for the multi-channel switch counter:
// FSM state encodings, tick-length derivations and a bit-width helper.
package ervp_multi_switch_counter_pkg;

    // Per-channel FSM state encodings
    localparam int unsigned STATE_W      = 2;
    localparam logic [1:0]  IDLE         = 2'd0;
    localparam logic [1:0]  PRESS_LOCK   = 2'd1;
    localparam logic [1:0]  HELD         = 2'd2;
    localparam logic [1:0]  RELEASE_LOCK = 2'd3;

    // Converts a duration in ms into a count of tick_1us pulses
    function automatic int unsigned ms_to_ticks(input int unsigned tick_hz,
                                                input int unsigned ms);
        return (tick_hz / 1000) * ms;
    endfunction

    // Debounce lockout length, applied after press and after release
    function automatic int unsigned lock_ticks(input int unsigned tick_hz,
                                               input int unsigned period_ms);
        return ms_to_ticks(tick_hz, period_ms);
    endfunction

    // Auto-repeat interval; 0 means repeat is disabled
    function automatic int unsigned rep_ticks(input int unsigned tick_hz,
                                              input int unsigned repeat_ms);
        return ms_to_ticks(tick_hz, repeat_ms);
    endfunction

    // Number of bits needed to hold v as an unsigned value (at least 1)
    function automatic int unsigned required_bitwidth_unsigned(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((v >> w) != 0)) begin
            w++;
        end
        return w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ervp_switch_channel.sv
// One switch channel: 2-flop synchroniser + polarity normalisation,
// debounce FSM with tick-based lockout timer, optional auto-repeat,
// and an up/down wrap/saturate event counter.
// Ports:
//   clk, rstnn         clock, async active-low reset
//   tick_1us           single-cycle timebase pulse
//   switch_input       raw asynchronous switch level
//   value_clear        synchronous clear of value (beats a same-cycle event)
//   value              channel counter
//   event_pulse        one-cycle pulse per accepted event
//   pressed            debounced level (PRESS_LOCK or HELD)
module ervp_switch_channel
    import ervp_multi_switch_counter_pkg::*;
#(
    parameter bit          ACTIVE_HIGH = 1'b0,
    parameter int unsigned LOCK_TICKS  = 20000,
    parameter int unsigned REP_TICKS   = 0,
    parameter int unsigned BW_VALUE    = 8,
    parameter bit          DOWN        = 1'b0,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                tick_1us,
    input  logic                switch_input,
    input  logic                value_clear,
    output logic [BW_VALUE-1:0] value,
    output logic                event_pulse,
    output logic                pressed
);

    localparam int unsigned   TIMER_W    = required_bitwidth_unsigned(max_u(LOCK_TICKS, REP_TICKS));
    localparam bit            REPEAT_EN  = (REP_TICKS != 0);
    localparam logic          IDLE_LEVEL = ACTIVE_HIGH ? 1'b0 : 1'b1;
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_TICKS - 1);
    localparam logic [TIMER_W-1:0] REP_LAST  = TIMER_W'(REPEAT_EN ? (REP_TICKS - 1) : 0);
    localparam logic [BW_VALUE-1:0] VALUE_MAX = '1;

    logic                sync_meta;
    logic                sync_out;
    logic                act;
    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_next;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_next;
    logic                ev_c;
    logic                lock_expire;
    logic                rep_expire;
    logic [BW_VALUE-1:0] value_next;

    // Synchroniser resets to the idle level; act is the registered, normalised press level
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            sync_meta <= IDLE_LEVEL;
            sync_out  <= IDLE_LEVEL;
            act       <= 1'b0;
        end else begin
            sync_meta <= switch_input;
            sync_out  <= sync_meta;
            act       <= ACTIVE_HIGH ? sync_out : ~sync_out;
        end
    end

    // State, timer and output registers
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state       <= IDLE;
            timer       <= '0;
            value       <= '0;
            event_pulse <= 1'b0;
            pressed     <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            value       <= value_next;
            event_pulse <= ev_c;
            pressed     <= (state_next == PRESS_LOCK) || (state_next == HELD);
        end
    end

    // Next-state, timer and event decode
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        ev_c        = 1'b0;
        lock_expire = tick_1us && (timer == LOCK_LAST);
        rep_expire  = REPEAT_EN && tick_1us && (timer == REP_LAST);

        case (state)
            IDLE: begin
                timer_next = '0;
                if (act) begin
                    state_next = PRESS_LOCK;
                    ev_c       = 1'b1;
                end
            end
            PRESS_LOCK: begin
                if (lock_expire) begin
                    state_next = act ? HELD : RELEASE_LOCK;
                end else if (tick_1us) begin
                    timer_next = timer + TIMER_W'(1);
                end
            end
            HELD: begin
                if (!act) begin
                    state_next = RELEASE_LOCK;
                end else if (rep_expire) begin
                    ev_c       = 1'b1;
                    timer_next = '0;
                end else if (REPEAT_EN && tick_1us) begin
                    timer_next = timer + TIMER_W'(1);
                end
            end
            RELEASE_LOCK: begin
                if (lock_expire) begin
                    state_next = IDLE;
                end else if (tick_1us) begin
                    timer_next = timer + TIMER_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every state change restarts the timer
        if (state_next != state) begin
            timer_next = '0;
        end
    end

    // Counter update; clear takes priority over a same-cycle event
    always_comb begin
        value_next = value;
        if (ev_c) begin
            if (DOWN) begin
                if (!(SATURATE && (value == '0))) begin
                    value_next = value - BW_VALUE'(1);
                end
            end else begin
                if (!(SATURATE && (value == VALUE_MAX))) begin
                    value_next = value + BW_VALUE'(1);
                end
            end
        end
        if (value_clear) begin
            value_next = '0;
        end
    end

endmodule

// File: rtl/ervp_multi_switch_counter.sv
// Multi-channel debounced push-switch event counter.
// Ports:
//   clk, rstnn         clock, async active-low reset
//   tick_1us           single-cycle timebase pulse at TICK_HZ
//   switch_input       raw switch levels, one per channel
//   value_clear        per-channel synchronous clear
//   value              packed counters, channel i at [i*BW_VALUE +: BW_VALUE]
//   event_pulse        per-channel one-cycle event pulse
//   pressed            per-channel debounced level
module ervp_multi_switch_counter
    import ervp_multi_switch_counter_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 4,
    parameter bit                ACTIVE_HIGH = 1'b0,
    parameter int unsigned       PERIOD_MS   = 20,
    parameter int unsigned       REPEAT_MS   = 0,
    parameter int unsigned       TICK_HZ     = 1000000,
    parameter int unsigned       BW_VALUE    = 8,
    parameter logic [NUM_CH-1:0] DOWN_MASK   = '0,
    parameter bit                SATURATE    = 1'b0
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic                       tick_1us,
    input  logic [NUM_CH-1:0]          switch_input,
    input  logic [NUM_CH-1:0]          value_clear,
    output logic [NUM_CH*BW_VALUE-1:0] value,
    output logic [NUM_CH-1:0]          event_pulse,
    output logic [NUM_CH-1:0]          pressed
);

    localparam int unsigned LOCK_TICKS = lock_ticks(TICK_HZ, PERIOD_MS);
    localparam int unsigned REP_TICKS  = rep_ticks(TICK_HZ, REPEAT_MS);

    // Parameter sanity checks at elaboration
    if (PERIOD_MS == 0) begin : g_bad_period
        $fatal(1, "ervp_multi_switch_counter: PERIOD_MS must be >= 1");
    end
    if ((TICK_HZ % 1000) != 0) begin : g_bad_tick
        $fatal(1, "ervp_multi_switch_counter: TICK_HZ must be a multiple of 1000");
    end
    if ((NUM_CH == 0) || (NUM_CH > 32)) begin : g_bad_num_ch
        $fatal(1, "ervp_multi_switch_counter: NUM_CH must be in 1..32");
    end

    // One independent channel per switch
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ervp_switch_channel #(
            .ACTIVE_HIGH (ACTIVE_HIGH),
            .LOCK_TICKS  (LOCK_TICKS),
            .REP_TICKS   (REP_TICKS),
            .BW_VALUE    (BW_VALUE),
            .DOWN        (DOWN_MASK[i]),
            .SATURATE    (SATURATE)
        ) u_ch (
            .clk          (clk),
            .rstnn        (rstnn),
            .tick_1us     (tick_1us),
            .switch_input (switch_input[i]),
            .value_clear  (value_clear[i]),
            .value        (value[i*BW_VALUE +: BW_VALUE]),
            .event_pulse  (event_pulse[i]),
            .pressed      (pressed[i])
        );
    end

endmodule

// File: tb/tb_ervp_multi_switch_counter.sv
// Directed bench for ervp_multi_switch_counter: four instances cover the
// plain counter, auto-repeat, and down-count wrap vs saturate.
module tb_ervp_multi_switch_counter;

    logic clk = 1'b0;
    logic rstnn;
    logic tick_1us = 1'b0;

    logic [1:0] msw, mclr, m_ev, m_pr;
    logic [7:0] m_value;
    logic [1:0] rsw, rclr, r_ev, r_pr;
    logic [7:0] r_value;
    logic [1:0] wsw, wclr, w_ev, w_pr, s_ev, s_pr;
    logic [7:0] w_value, s_value;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;
    int unsigned ev_m0 = 0, ev_m1 = 0, ev_w1 = 0, ev_s1 = 0, rep_n = 0;
    int unsigned rep_t[4];
    int unsigned eb;

    always #5 clk = ~clk;

    ervp_multi_switch_counter #(.NUM_CH(2), .ACTIVE_HIGH(1'b0), .PERIOD_MS(1), .REPEAT_MS(0),
        .TICK_HZ(1000000), .BW_VALUE(4), .DOWN_MASK(2'b00), .SATURATE(1'b0)) u_main (
        .clk(clk), .rstnn(rstnn), .tick_1us(tick_1us), .switch_input(msw),
        .value_clear(mclr), .value(m_value), .event_pulse(m_ev), .pressed(m_pr));

    ervp_multi_switch_counter #(.NUM_CH(2), .ACTIVE_HIGH(1'b0), .PERIOD_MS(1), .REPEAT_MS(2),
        .TICK_HZ(1000000), .BW_VALUE(4), .DOWN_MASK(2'b00), .SATURATE(1'b0)) u_rep (
        .clk(clk), .rstnn(rstnn), .tick_1us(tick_1us), .switch_input(rsw),
        .value_clear(rclr), .value(r_value), .event_pulse(r_ev), .pressed(r_pr));

    // Short lockout (10 ticks) so the 17-press sequences stay cheap
    ervp_multi_switch_counter #(.NUM_CH(2), .ACTIVE_HIGH(1'b0), .PERIOD_MS(1), .REPEAT_MS(0),
        .TICK_HZ(10000), .BW_VALUE(4), .DOWN_MASK(2'b10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rstnn(rstnn), .tick_1us(tick_1us), .switch_input(wsw),
        .value_clear(wclr), .value(w_value), .event_pulse(w_ev), .pressed(w_pr));

    ervp_multi_switch_counter #(.NUM_CH(2), .ACTIVE_HIGH(1'b0), .PERIOD_MS(1), .REPEAT_MS(0),
        .TICK_HZ(10000), .BW_VALUE(4), .DOWN_MASK(2'b10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rstnn(rstnn), .tick_1us(tick_1us), .switch_input(wsw),
        .value_clear(wclr), .value(s_value), .event_pulse(s_ev), .pressed(s_pr));

    // tick_1us: one cycle in every four
    always @(posedge clk) begin
        #1;
        cyc++;
        tick_1us = ((cyc % 4) == 0);
    end

    // Event counters and repeat timestamps
    always @(negedge clk) begin
        if (rstnn) begin
            if (m_ev[0]) ev_m0++;
            if (m_ev[1]) ev_m1++;
            if (w_ev[1]) ev_w1++;
            if (s_ev[1]) ev_s1++;
            if (r_ev[0]) begin
                if (rep_n < 4) rep_t[rep_n] = cyc;
                rep_n++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rstnn = 1'b0;
        msw = 2'b11; mclr = 2'b00;
        rsw = 2'b11; rclr = 2'b00;
        wsw = 2'b11; wclr = 2'b00;
        step(3);
        chk("reset_value",   32'(m_value), 0);
        chk("reset_event",   32'(m_ev), 0);
        chk("reset_pressed", 32'(m_pr), 0);
        rstnn = 1'b1;
        step(5);

        // Single clean press on ch0, held 1500 ticks
        eb = ev_m0;
        msw[0] = 1'b0;
        step(3);
        chk("press_lat_early", 32'(m_ev[0]), 0);
        step(1);
        chk("press_event",   32'(m_ev[0]), 1);
        chk("press_value",   32'(m_value[3:0]), 1);
        chk("press_pressed", 32'(m_pr[0]), 1);
        step(1);
        chk("press_event_one_cycle", 32'(m_ev[0]), 0);
        step(5995);
        msw[0] = 1'b1;
        step(4400);
        chk("single_event_count", ev_m0 - eb, 1);
        chk("single_value0",      32'(m_value[3:0]), 1);
        chk("single_value1",      32'(m_value[7:4]), 0);
        chk("single_ch1_events",  ev_m1, 0);
        chk("single_released",    32'(m_pr[0]), 0);

        // Bouncy press and bouncy release on ch0
        eb = ev_m0;
        for (int i = 0; i < 5; i++) begin
            msw[0] = ~msw[0];
            step(160);
            if (i == 1) chk("bounce_lock_pressed", 32'(m_pr[0]), 1);
        end
        step(5200);
        chk("bounce_held_pressed", 32'(m_pr[0]), 1);
        for (int i = 0; i < 5; i++) begin
            msw[0] = ~msw[0];
            step(160);
            if (i == 0) chk("bounce_release_drop", 32'(m_pr[0]), 0);
        end
        step(3600);
        chk("bounce_event_count", ev_m0 - eb, 1);
        chk("bounce_value0",      32'(m_value[3:0]), 2);
        chk("bounce_idle",        32'(m_pr[0]), 0);

        // Auto-repeat: 5500-tick hold with 2000-tick repeat
        rsw[0] = 1'b0;
        step(22000);
        rsw[0] = 1'b1;
        step(4400);
        chk("repeat_value0",  32'(r_value[3:0]), 3);
        chk("repeat_events",  rep_n, 3);
        chk("repeat_spacing", rep_t[2] - rep_t[1], 8000);
        chk("repeat_value1",  32'(r_value[7:4]), 0);

        // 7 simultaneous presses on both channels
        for (int i = 0; i < 7; i++) begin
            wsw = 2'b00;
            step(60);
            wsw = 2'b11;
            step(60);
        end
        chk("both_wrap_ch0", 32'(w_value[3:0]), 7);
        chk("both_wrap_ch1", 32'(w_value[7:4]), 9);
        chk("both_sat_ch0",  32'(s_value[3:0]), 7);
        chk("both_sat_ch1",  32'(s_value[7:4]), 0);

        // 10 more presses on ch1 only: 17 decrements in total
        for (int i = 0; i < 10; i++) begin
            wsw = 2'b01;
            step(60);
            wsw = 2'b11;
            step(60);
        end
        chk("wrap_ch1_value",  32'(w_value[7:4]), 15);
        chk("sat_ch1_value",   32'(s_value[7:4]), 0);
        chk("wrap_ch1_events", ev_w1, 17);
        chk("sat_ch1_events",  ev_s1, 17);
        chk("wrap_ch0_kept",   32'(w_value[3:0]), 7);

        // Clear lands on the same edge as the ch0 event
        wsw[0] = 1'b0;
        step(3);
        chk("clr_pre_value", 32'(w_value[3:0]), 7);
        wclr = 2'b01;
        step(1);
        chk("clr_event",       32'(w_ev[0]), 1);
        chk("clr_wrap_value",  32'(w_value[3:0]), 0);
        chk("clr_sat_value",   32'(s_value[3:0]), 0);
        chk("clr_fsm_pressed", 32'(w_pr[0]), 1);
        chk("clr_ch1_kept",    32'(w_value[7:4]), 15);
        wclr = 2'b00;
        step(60);
        wsw[0] = 1'b1;
        step(60);

        // Reset during PRESS_LOCK with the switch still held
        msw[0] = 1'b0;
        step(4);
        chk("prereset_value", 32'(m_value[3:0]), 3);
        step(100);
        rstnn = 1'b0;
        step(1);
        chk("inreset_value",   32'(m_value), 0);
        chk("inreset_event",   32'(m_ev), 0);
        chk("inreset_pressed", 32'(m_pr), 0);
        step(2);
        rstnn = 1'b1;
        step(3);
        chk("postreset_early", 32'(m_ev[0]), 0);
        step(1);
        chk("postreset_event",   32'(m_ev[0]), 1);
        chk("postreset_value",   32'(m_value[3:0]), 1);
        chk("postreset_pressed", 32'(m_pr[0]), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ervp_multi_switch_counter.md
Name: ervp_multi_switch_counter

Overview:
- Multi-channel, debounced push-switch event counter for board-level user input: buttons to software-visible counts.
- Per channel: synchronises a raw switch and debounces both edges against a tick-based lockout. Counts one event per press, plus optional auto-repeat while held.
- Per channel: counts up or down, with wrap or saturate.
- Sits in the external peripheral group; values are read through the APB register wrapper.

Parameters:
- NUM_CH, 4, number of independent switch channels (1..32).
- ACTIVE_HIGH, 0, 1 means the switch is pressed when input is 1; 0 means pressed when input is 0.
- PERIOD_MS, 20, debounce lockout after press and after release, in ms (>=1).
- REPEAT_MS, 0, auto-repeat interval while held, in ms; 0 disables repeat.
- TICK_HZ, 1000000, frequency of tick_1us pulses.
- BW_VALUE, 8, width of each channel counter.
- DOWN_MASK, 0, bit i set means channel i decrements.
- SATURATE, 0, 0 wraps at the limits; 1 clamps at 0 and 2^BW_VALUE-1.

Ports:
- clk  input  1  system clock.
- rstnn  input  1  reset, asynchronous, active-low.
- tick_1us  input  1  single-cycle timebase pulse at TICK_HZ.
- switch_input  input  NUM_CH  raw asynchronous switch levels.
- value_clear  input  NUM_CH  synchronous per-channel clear of the value to 0.
- value  output  NUM_CH*BW_VALUE  packed counters; channel i is at bits [i*BW_VALUE +: BW_VALUE].
- event_pulse  output  NUM_CH  one-cycle pulse per accepted event.
- pressed  output  NUM_CH  debounced level: 1 in PRESS_LOCK and in HELD.

Behaviour:
- Reset: value=0, event_pulse=0, pressed=0, all FSMs IDLE, timers 0, synchroniser flops hold the inactive level.
- Synchroniser: a 2-flop synchroniser, then polarity normalisation, gives act[i].
- Lockout length: LOCK_TICKS = TICK_HZ/1000*PERIOD_MS.
- Repeat length: REP_TICKS = TICK_HZ/1000*REPEAT_MS.
- Timer width: REQUIRED_BITWIDTH_UNSIGNED of the larger length.
- Timer advance: the timer advances only on tick_1us. It expires when tick_1us=1 and timer==LEN-1. It clears to 0 on every state change.
- FSM states and transitions, per channel:
  - IDLE: when act=1, go to PRESS_LOCK and raise an event in the same cycle.
  - PRESS_LOCK: the input is ignored until expiry. On expiry, go to HELD if act=1, otherwise go to RELEASE_LOCK.
  - HELD: when act=0, go to RELEASE_LOCK. When act=1 and REPEAT_MS!=0, raise an event and restart the timer on each repeat expiry.
  - RELEASE_LOCK: the input is ignored. On expiry, go to IDLE.
- Event latency: if the input is stable active before clock edge k, act is high after edge k+2. The FSM leaves IDLE at edge k+3, and value updates at that same edge. event_pulse is high for the one cycle following edge k+3.
- Arithmetic: each event adds +1 or -1 per DOWN_MASK.
  - SATURATE=0: modulo 2^BW_VALUE (255+1 gives 0; 0-1 gives 255).
  - SATURATE=1: holds at the limit.
  - event_pulse still asserts when saturated.
- Simultaneous events: value_clear beats an event in the same cycle; the value becomes 0, event_pulse still asserts, and the FSM is unaffected.
- Channel independence: channels are fully independent. Simultaneous events on several channels all count.
- Reset mid-operation: reset at any time returns every channel to the reset state. A switch still held after reset is treated as a new press, counted after the 3-cycle latency.
- Glitches: a glitch shorter than 2 clocks may or may not be captured. Once captured, it costs exactly one event plus a full press lockout and a full release lockout.
- Elaboration checks: PERIOD_MS < 1 is a fatal error. TICK_HZ not divisible by 1000 is a fatal error.

Decomposition:
- Shared include ervp_multi_switch_counter.vh holds:
  - the FSM state localparams: IDLE=2'd0, PRESS_LOCK=2'd1, HELD=2'd2, RELEASE_LOCK=2'd3;
  - the LOCK_TICKS and REP_TICKS derivation functions.
- One sub-module, ervp_switch_channel: synchroniser, FSM, timer and counter for a single channel.
- The top level instantiates ervp_switch_channel NUM_CH times in a generate loop and packs the outputs.

Test Plan:
Common setup: NUM_CH=2, TICK_HZ=1000000, PERIOD_MS=1, BW_VALUE=4, ACTIVE_HIGH=0, tick_1us every 4 clocks.
- Single clean press: ch0 goes low at edge 10 and is held for 1500 ticks, then released. Required: one event_pulse after edge 13, value0=1, no further events, value1=0.
- Bounce: ch0 toggles 5 times within 200 ticks, then is stable low, then released with 5 bounces. Required: exactly one event; pressed drops only after release.
- Auto-repeat: REPEAT_MS=2, hold for 5500 ticks. Required: value0=3 (press + 2 repeats), with repeat events spaced 2000 ticks apart.
- Wrap vs saturate: DOWN_MASK=2'b10, 17 presses on ch1. With SATURATE=0, value1=15 (0-17 mod 16). With SATURATE=1, value1=0 and all 17 event_pulses are seen.
- Clear collision: assert value_clear[0] in the same cycle as ch0 event_pulse with value0=7. Required: value0=0 and event_pulse=1.
- Reset mid-lockout: rstnn low for 3 cycles during PRESS_LOCK with the switch still held. Required: value=0, event_pulse=0 and pressed=0 during reset; one new event 3 cycles after release of reset.
